// File: rtl/r2_pkg.sv
// Shared constants for the r2 pair pipeline:
// FP32 field layout, word width and r2_compute latency.
package r2_pkg;

  localparam int R2_DATA_WIDTH   = 32;
  localparam int R2_PIPE_LATENCY = 17;

  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;

  localparam logic [7:0] FP_EXP_ONES = 8'hFF;

endpackage

// File: rtl/r2_cutoff_filter_if.sv
// Valid/ready stream carrying one in-range pair
// (r2, dx, dy, dz) towards force evaluation.
interface r2_cutoff_filter_if
  import r2_pkg::*;
#(
  parameter int DATA_WIDTH = R2_DATA_WIDTH
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] r2;
  logic [DATA_WIDTH-1:0] dx;
  logic [DATA_WIDTH-1:0] dy;
  logic [DATA_WIDTH-1:0] dz;

  modport master (
    output valid, r2, dx, dy, dz,
    input  ready
  );

  modport slave (
    input  valid, r2, dx, dy, dz,
    output ready
  );

endinterface

// File: rtl/pair_fifo.sv
// Show-ahead synchronous FIFO with a registered head word,
// registered empty flag and a free-space threshold flag.
module pair_fifo #(
  parameter int WIDTH   = 128,
  parameter int DEPTH   = 32,
  parameter int AF_FREE = 17,
  localparam int PW     = $clog2(DEPTH),
  localparam int AW     = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [AW-1:0]    occupancy,
  output logic             almost_full
);

  localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);
  localparam logic [AW-1:0] FREE_C  = AW'(AF_FREE);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;
  logic [AW-1:0]    count;
  logic [AW-1:0]    count_next;
  logic             pop_ok;
  logic             push_ok;
  logic [WIDTH-1:0] head_next;

  assign pop_ok    = pop && (count != '0);
  assign push_ok   = push && ((count != DEPTH_C) || pop_ok);
  assign rd_next   = rd_ptr + PW'(pop_ok);
  assign occupancy = count;

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + 1'b1;
    else if (!push_ok && pop_ok)
      count_next = count - 1'b1;
  end

  // The new head comes straight from wdata when nothing older survives.
  always_comb begin
    head_next = rdata;
    if (count_next != '0) begin
      if (count == AW'(pop_ok))
        head_next = wdata;
      else
        head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rdata       <= '0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr      <= rd_next;
      count       <= count_next;
      rdata       <= head_next;
      empty       <= (count_next == '0);
      almost_full <= (DEPTH_C - count_next) <= FREE_C;
    end
  end

endmodule

// File: rtl/r2_cutoff_filter.sv
// Cutoff test on the r2_compute stream; in-range pairs are
// buffered for force evaluation, with drop/accept statistics.
module r2_cutoff_filter
  import r2_pkg::*;
#(
  parameter int DATA_WIDTH = R2_DATA_WIDTH,
  parameter int FIFO_DEPTH = 32,
  parameter int PIPE_SLACK = R2_PIPE_LATENCY,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r2_valid,
  input  logic [DATA_WIDTH-1:0] r2,
  input  logic [DATA_WIDTH-1:0] dx,
  input  logic [DATA_WIDTH-1:0] dy,
  input  logic [DATA_WIDTH-1:0] dz,
  input  logic [DATA_WIDTH-1:0] cutoff2,
  r2_cutoff_filter_if.master    pair_out,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  accept_count,
  output logic [CNT_WIDTH-1:0]  reject_count
);

  localparam int AW = $clog2(FIFO_DEPTH) + 1;
  localparam int W4 = 4 * DATA_WIDTH;

  logic [FP_SIGN_BIT-1:0] r2_mag;
  logic [FP_SIGN_BIT-1:0] cut_mag;
  logic                   unused_sign;
  logic                   in_range;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   drop;
  logic                   empty;
  logic [AW-1:0]          occupancy;
  logic [W4-1:0]          head;

  // Both operands are non-negative, so magnitude bits order like integers.
  assign r2_mag      = r2[FP_SIGN_BIT-1:0];
  assign cut_mag     = cutoff2[FP_SIGN_BIT-1:0];
  assign unused_sign = cutoff2[FP_SIGN_BIT];

  assign in_range = (r2_mag != '0)
                 && (r2[FP_EXP_MSB:FP_EXP_LSB] != FP_EXP_ONES)
                 && (r2_mag < cut_mag);

  assign push = r2_valid && in_range;
  assign pop  = pair_out.valid && pair_out.ready;
  assign full = occupancy[AW-1];
  assign drop = push && full && !pop;

  pair_fifo #(
    .WIDTH   (W4),
    .DEPTH   (FIFO_DEPTH),
    .AF_FREE (PIPE_SLACK)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .wdata       ({r2, dx, dy, dz}),
    .pop         (pop),
    .rdata       (head),
    .empty       (empty),
    .occupancy   (occupancy),
    .almost_full (almost_full)
  );

  assign pair_out.valid = !empty;
  assign pair_out.r2    = head[4*DATA_WIDTH-1:3*DATA_WIDTH];
  assign pair_out.dx    = head[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign pair_out.dy    = head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign pair_out.dz    = head[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow     <= 1'b0;
      accept_count <= '0;
      reject_count <= '0;
    end else begin
      if (drop)
        overflow <= 1'b1;
      if (push && !drop && (accept_count != '1))
        accept_count <= accept_count + 1'b1;
      if (r2_valid && !in_range && (reject_count != '1))
        reject_count <= reject_count + 1'b1;
    end
  end

endmodule

// File: doc/r2_cutoff_filter.md
Name: r2_cutoff_filter

Overview:
Consumer of the r2_compute output stream. Each valid r2/dx/dy/dz result is compared against the squared cutoff radius. In-range pairs go into a FIFO and are presented to the downstream force-evaluation pipeline through a valid/ready handshake. The block also raises an almost-full hint so the upstream pair generator can stall `enable` before the r2 pipeline's in-flight results can overflow the buffer.

Parameters:
DATA_WIDTH, 32, width of the FP32 r2/dx/dy/dz words
FIFO_DEPTH, 32, number of buffered in-range pairs; power of two, at least 32
PIPE_SLACK, 17, r2_compute latency in cycles; reserved entries for results already in flight
CNT_WIDTH, 16, width of the accepted and rejected counters

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
r2_valid  in  1  r2/dx/dy/dz valid this cycle; no backpressure into r2_compute
r2  in  DATA_WIDTH  squared distance, FP32
dx  in  DATA_WIDTH  x displacement, FP32
dy  in  DATA_WIDTH  y displacement, FP32
dz  in  DATA_WIDTH  z displacement, FP32
cutoff2  in  DATA_WIDTH  squared cutoff, FP32, positive; quasi-static
out_valid  out  1  FIFO head holds a pair
out_ready  in  1  downstream accepts the head this cycle
out_r2  out  DATA_WIDTH  head r2
out_dx  out  DATA_WIDTH  head dx
out_dy  out  DATA_WIDTH  head dy
out_dz  out  DATA_WIDTH  head dz
almost_full  out  1  free entries at or below PIPE_SLACK; upstream must deassert enable
overflow  out  1  sticky: an in-range pair was dropped
accept_count  out  CNT_WIDTH  in-range pairs pushed; saturating
reject_count  out  CNT_WIDTH  out-of-range pairs discarded; saturating

Behaviour:
- Reset (asynchronous, active-high): FIFO empty, pointers 0, out_valid=0, out_r2/dx/dy/dz=0, almost_full=0, overflow=0, both counters 0. Reset mid-stream discards all buffered and arriving data.
- Compare (combinational, no FP IP): treat r2 and cutoff2 as unsigned bit patterns with the sign bit masked, since both are non-negative.
  - in_range = (r2[30:0] != 0) && (r2[30:23] != 8'hFF) && (r2[30:0] < cutoff2[30:0]).
  - The test is strict less-than: r2 equal to cutoff2 is rejected.
  - r2 = ±0 (self pair) is rejected.
  - Infinity and NaN are rejected.
- Input cycle with r2_valid=1:
  - in_range=1: push {r2,dx,dy,dz} and increment accept_count.
  - in_range=0: increment reject_count; nothing is stored.
  - Counters saturate at all-ones.
- Push when full:
  - If a pop occurs in the same cycle, the push succeeds (simultaneous push/pop at full is legal).
  - Otherwise the pair is dropped, overflow is set sticky until reset, and accept_count is not incremented.
- Pop: occurs when out_valid && out_ready. Popping while empty has no effect.
- Output model: show-ahead. out_* reflect the head entry; out_valid = !empty, registered.
  - Latency for a pair arriving at an empty FIFO at edge N: out_valid=1 and data visible after edge N+1 (one cycle).
  - Simultaneous push and pop at occupancy 1: out_valid stays 1 and the head advances to the new entry.
  - Out_* must hold stable while out_valid=1 and out_ready=0.
- Occupancy counter: width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- almost_full: registered, = (FIFO_DEPTH − occupancy_next) <= PIPE_SLACK. Evaluated every cycle; deasserts as soon as free space exceeds PIPE_SLACK.
- cutoff2 changes while pairs are in flight take effect on the next compare. Pairs already buffered are unaffected.

Decomposition:
- Shared package r2_pkg holds:
  - FP32 field constants: sign bit index, exponent MSB/LSB, exponent all-ones value.
  - DATA_WIDTH default.
  - R2_PIPE_LATENCY = 17, shared with r2_compute so PIPE_SLACK tracks the pipeline.
- One natural sub-module: pair_fifo.
  - Generic show-ahead synchronous FIFO: width 4*DATA_WIDTH, depth FIFO_DEPTH.
  - Outputs: full, empty, occupancy, almost_full threshold output.
  - The top level keeps only the compare, counters and overflow logic.

Test Plan:
- cutoff2=32'h41200000 (10.0); r2=32'h40400000 (3.0), dx=dy=dz=32'hBF800000 -> accept_count=1, out_valid=1 one cycle later, out_r2=32'h40400000, out_dx=32'hBF800000.
- Same cutoff; r2=32'h426C0000 (59.0), then r2=32'h41200000 (10.0, equal to cutoff) -> both rejected, reject_count=2, out_valid stays 0.
- r2=32'h00000000, then 32'h80000000, then 32'h7FC00000 (NaN) -> all rejected, reject_count=3, accept_count=0.
- out_ready=0, 15 in-range pairs -> almost_full=1 after the 15th push (free space 17); the 33rd push is dropped and overflow=1; accept_count=32; draining then yields all 32 pairs in order.
- FIFO full, out_ready=1 and an in-range push in the same cycle -> no overflow, occupancy stays 32, head advances.
- rst asserted mid-stream with 5 entries buffered -> out_valid=0, counters 0, overflow 0 immediately without a clock edge; the first post-reset pair emerges one cycle after its arrival.
